// File: rtl/mem_stage_if.sv
// ex_out_if: EX -> MEM result bundle.
// The ctrl group is carried as individual flag signals (mem_r .. udf, sz,
// mem_sx, w_rd, w_cr, cmp_res) so consumers reach them as ex.<flag>.
//   modport ex    : EX stage drives the bundle
//   modport other : MEM stage consumes the bundle
interface ex_out_if;
  logic [31:0] pc;
  logic [31:0] nextpc;
  logic [31:0] alu_res;
  logic [31:0] op3;
  logic [4:0]  rd;
  logic        bubble;
  // ctrl
  logic        mem_r;
  logic        mem_w;
  logic        io_r;
  logic        io_w;
  logic [1:0]  sz;      // 0 byte, 1 half, 2 word
  logic        mem_sx;  // sign-extend loads
  logic        link;
  logic        mfsr;
  logic        mfcr;
  logic        mtsr;
  logic        scall;
  logic        eret;
  logic        udf;
  logic        w_rd;
  logic        w_cr;
  logic [1:0]  cmp_res;

  modport ex (
    output pc, nextpc, alu_res, op3, rd, bubble, mem_r, mem_w, io_r, io_w,
           sz, mem_sx, link, mfsr, mfcr, mtsr, scall, eret, udf, w_rd, w_cr, cmp_res
  );
  modport other (
    input pc, nextpc, alu_res, op3, rd, bubble, mem_r, mem_w, io_r, io_w,
          sz, mem_sx, link, mfsr, mfcr, mtsr, scall, eret, udf, w_rd, w_cr, cmp_res
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory/IO pipeline stage.
// Issues data-memory and IO-port transactions, moves system registers,
// signals traps and produces a registered writeback bundle.
// Ports:
//   clk, rst (async, active-high)
//   ex                   EX result bundle (ex_out_if.other)
//   stall                hold IF/ID/EX while a bus op is outstanding
//   dm_*                 data-memory req/ack handshake (req held until ack)
//   io_*                 IO-port req/ack handshake (same protocol)
//   sr_idx/sr_we/sr_wdata/sr_rdata  system-register access
//   cr_rdata             condition-register read data (mfcr)
//   wb_*                 registered writeback bundle
//   exc_valid/exc_cause/exc_pc      one-cycle trap pulse
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses (cause 3) instead of aligning them down.
module mem_stage #(
  parameter int SR_AW = 5,
  parameter int IO_AW = 16
) (
  input  logic             clk,
  input  logic             rst,
  ex_out_if.other          ex,
  output logic             stall,
  output logic             dm_req,
  output logic             dm_we,
  output logic [31:0]      dm_addr,
  output logic [3:0]       dm_be,
  output logic [31:0]      dm_wdata,
  input  logic [31:0]      dm_rdata,
  input  logic             dm_ack,
  output logic             io_req,
  output logic             io_we,
  output logic [IO_AW-1:0] io_addr,
  output logic [31:0]      io_wdata,
  input  logic [31:0]      io_rdata,
  input  logic             io_ack,
  output logic [SR_AW-1:0] sr_idx,
  output logic             sr_we,
  output logic [31:0]      sr_wdata,
  input  logic [31:0]      sr_rdata,
  input  logic [31:0]      cr_rdata,
  output logic             wb_valid,
  output logic             wb_w_rd,
  output logic             wb_w_cr,
  output logic [4:0]       wb_rd,
  output logic [31:0]      wb_data,
  output logic [1:0]       wb_cr,
  output logic [31:0]      wb_pc,
  output logic             exc_valid,
  output logic [1:0]       exc_cause,
  output logic [31:0]      exc_pc
);

  typedef enum logic [1:0] {IDLE, DM_WAIT, IO_WAIT} state_t;
  state_t state, state_d;

  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'd0:    lane_be = 4'b0001 << a;
      2'd1:    lane_be = 4'b0011 << {a[1], 1'b0};
      default: lane_be = 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] v);
    case (sz)
      2'd0:    lane_wdata = {4{v[7:0]}};
      2'd1:    lane_wdata = {2{v[15:0]}};
      default: lane_wdata = v;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [1:0] sz, input logic [1:0] a,
                                           input logic sx, input logic [31:0] rdata);
    logic [1:0]  sh;
    logic [31:0] v;
    sh = (sz == 2'd0) ? a : (sz == 2'd1) ? {a[1], 1'b0} : 2'd0;
    v  = rdata >> {sh, 3'b000};
    case (sz)
      2'd0:    load_ext = {{24{sx & v[7]}}, v[7:0]};
      2'd1:    load_ext = {{16{sx & v[15]}}, v[15:0]};
      default: load_ext = v;
    endcase
  endfunction

  // Request-stage copies of the instruction held while the bus op is pending
  logic [4:0]       rd_p1;
  logic             w_rd_p1, w_cr_p1, load_p1, sx_p1;
  logic [1:0]       cr_p1, sz_p1, a_p1;
  logic [31:0]      pc_p1, alt_p1;
  logic [SR_AW-1:0] sr_widx_p1;

  logic        valid, hazard, accept, trap, mis, issue_dm, issue_io, bus_ack, stall_c;
  logic [1:0]  a, cause;
  logic [31:0] alt;

  assign valid = !ex.bubble;
  assign a     = ex.alu_res[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = (ex.mem_r | ex.mem_w) &
               (((ex.sz == 2'd1) & a[0]) | ((ex.sz == 2'd2) & (a != 2'd0)));
`else
  assign mis = 1'b0;
`endif

  // A pending sr_we owns sr_idx this cycle, so an mfsr waits one cycle and
  // then reads the freshly written value.
  assign hazard   = valid & ex.mfsr & sr_we;
  assign accept   = valid & !hazard;
  assign trap     = ex.udf | ex.scall | ex.eret | mis;
  assign cause    = ex.udf ? 2'd2 : ex.scall ? 2'd0 : ex.eret ? 2'd1 : 2'd3;
  assign issue_dm = accept & !trap & (ex.mem_r | ex.mem_w);
  assign issue_io = accept & !trap & !(ex.mem_r | ex.mem_w) & (ex.io_r | ex.io_w);
  assign bus_ack  = ((state == DM_WAIT) & dm_ack) | ((state == IO_WAIT) & io_ack);
  assign alt      = ex.link ? ex.nextpc : ex.mfsr ? sr_rdata : ex.mfcr ? cr_rdata : ex.alu_res;
  assign sr_idx   = sr_we ? sr_widx_p1 : ex.alu_res[SR_AW-1:0];
  // Reset kills stall immediately, even while EX still presents a bus op.
  assign stall    = stall_c & !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    stall_c = 1'b0;
    case (state)
      IDLE: begin
        if (hazard) begin
          stall_c = 1'b1;
        end else if (issue_dm) begin
          state_d = DM_WAIT;
          stall_c = 1'b1;
        end else if (issue_io) begin
          state_d = IO_WAIT;
          stall_c = 1'b1;
        end
      end
      DM_WAIT, IO_WAIT: begin
        stall_c = !bus_ack;
        if (bus_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- request / writeback stage boundary ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dm_req <= 1'b0; dm_we <= 1'b0; dm_addr <= '0; dm_be <= '0; dm_wdata <= '0;
      io_req <= 1'b0; io_we <= 1'b0; io_addr <= '0; io_wdata <= '0;
      sr_we <= 1'b0; sr_wdata <= '0; sr_widx_p1 <= '0;
      wb_valid <= 1'b0; wb_w_rd <= 1'b0; wb_w_cr <= 1'b0; wb_rd <= '0;
      wb_data <= '0; wb_cr <= '0; wb_pc <= '0;
      exc_valid <= 1'b0; exc_cause <= '0; exc_pc <= '0;
      rd_p1 <= '0; w_rd_p1 <= 1'b0; w_cr_p1 <= 1'b0; load_p1 <= 1'b0; sx_p1 <= 1'b0;
      cr_p1 <= '0; sz_p1 <= '0; a_p1 <= '0; pc_p1 <= '0; alt_p1 <= '0;
    end else begin
      wb_valid  <= 1'b0;
      exc_valid <= 1'b0;
      sr_we     <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            rd_p1   <= ex.rd;
            w_cr_p1 <= ex.w_cr;
            cr_p1   <= ex.cmp_res;
            pc_p1   <= ex.pc;
            alt_p1  <= alt;
            sz_p1   <= ex.sz;
            a_p1    <= a;
            sx_p1   <= ex.mem_sx;
            if (trap) begin
              exc_valid <= 1'b1;
              exc_cause <= cause;
              exc_pc    <= ex.pc;
              wb_valid  <= 1'b1;
              wb_w_rd   <= 1'b0;
              wb_w_cr   <= 1'b0;
              wb_rd     <= ex.rd;
              wb_pc     <= ex.pc;
            end else if (issue_dm) begin
              dm_req   <= 1'b1;
              dm_we    <= ex.mem_w;
              dm_addr  <= {ex.alu_res[31:2], 2'b00};
              dm_be    <= lane_be(ex.sz, a);
              dm_wdata <= lane_wdata(ex.sz, ex.op3);
              load_p1  <= ex.mem_r;
              w_rd_p1  <= ex.w_rd & !ex.mem_w;
            end else if (issue_io) begin
              io_req   <= 1'b1;
              io_we    <= ex.io_w;
              io_addr  <= ex.alu_res[IO_AW-1:0];
              io_wdata <= ex.op3;
              load_p1  <= ex.io_r;
              w_rd_p1  <= ex.w_rd & !ex.io_w;
            end else begin
              wb_valid   <= 1'b1;
              wb_w_rd    <= ex.w_rd;
              wb_w_cr    <= ex.w_cr;
              wb_cr      <= ex.cmp_res;
              wb_rd      <= ex.rd;
              wb_pc      <= ex.pc;
              wb_data    <= alt;
              sr_we      <= ex.mtsr;
              sr_wdata   <= ex.op3;
              sr_widx_p1 <= ex.alu_res[SR_AW-1:0];
            end
          end
        end
        default: begin
          if (bus_ack) begin
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            io_req   <= 1'b0;
            io_we    <= 1'b0;
            wb_valid <= 1'b1;
            wb_w_rd  <= w_rd_p1;
            wb_w_cr  <= w_cr_p1;
            wb_cr    <= cr_p1;
            wb_rd    <= rd_p1;
            wb_pc    <= pc_p1;
            if (!load_p1)              wb_data <= alt_p1;
            else if (state == IO_WAIT) wb_data <= io_rdata;
            else                       wb_data <= load_ext(sz_p1, a_p1, sx_p1, dm_rdata);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: hand-computed vectors covering reset,
// ALU/link/sysreg writeback, byte/half/word loads and stores, IO reads,
// traps, back-to-back issue and reset mid-transaction.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        dm_ack;
  logic        io_req, io_we;
  logic [15:0] io_addr;
  logic [31:0] io_wdata, io_rdata;
  logic        io_ack;
  logic [4:0]  sr_idx;
  logic        sr_we;
  logic [31:0] sr_wdata, sr_rdata, cr_rdata;
  logic        wb_valid, wb_w_rd, wb_w_cr;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, wb_pc;
  logic [1:0]  wb_cr;
  logic        exc_valid;
  logic [1:0]  exc_cause;
  logic [31:0] exc_pc;

  int n_vec = 0;
  int n_err = 0;

  ex_out_if ex_bus();

  mem_stage #(.SR_AW(5), .IO_AW(16)) dut (
    .clk(clk), .rst(rst), .ex(ex_bus), .stall(stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .io_ack(io_ack),
    .sr_idx(sr_idx), .sr_we(sr_we), .sr_wdata(sr_wdata), .sr_rdata(sr_rdata),
    .cr_rdata(cr_rdata),
    .wb_valid(wb_valid), .wb_w_rd(wb_w_rd), .wb_w_cr(wb_w_cr), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_cr(wb_cr), .wb_pc(wb_pc),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    ex_bus.pc = '0; ex_bus.nextpc = '0; ex_bus.alu_res = '0; ex_bus.op3 = '0;
    ex_bus.rd = '0; ex_bus.bubble = 1'b1;
    ex_bus.mem_r = 1'b0; ex_bus.mem_w = 1'b0; ex_bus.io_r = 1'b0; ex_bus.io_w = 1'b0;
    ex_bus.sz = 2'd0; ex_bus.mem_sx = 1'b0; ex_bus.link = 1'b0; ex_bus.mfsr = 1'b0;
    ex_bus.mfcr = 1'b0; ex_bus.mtsr = 1'b0; ex_bus.scall = 1'b0; ex_bus.eret = 1'b0;
    ex_bus.udf = 1'b0; ex_bus.w_rd = 1'b0; ex_bus.w_cr = 1'b0; ex_bus.cmp_res = '0;
  endtask

  initial begin
    int stalls;
    rst = 1'b1;
    dm_ack = 1'b0; io_ack = 1'b0;
    dm_rdata = '0; io_rdata = '0; sr_rdata = '0; cr_rdata = 32'h0000_0C0C;
    clr();
    step(); step();
    check("rst_stall", stall, 0);
    check("rst_dm_req", dm_req, 0);
    check("rst_io_req", io_req, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_exc_valid", exc_valid, 0);
    check("rst_sr_we", sr_we, 0);
    rst = 1'b0;
    step();

    // ALU op: single cycle writeback, cr bits forwarded
    clr(); ex_bus.bubble = 1'b0; ex_bus.alu_res = 32'h0000_1111; ex_bus.w_rd = 1'b1;
    ex_bus.rd = 5'd3; ex_bus.pc = 32'h100; ex_bus.w_cr = 1'b1; ex_bus.cmp_res = 2'd2;
    #1 check("alu_stall", stall, 0);
    step();
    check("alu_wb_valid", wb_valid, 1);
    check("alu_wb_data", wb_data, 32'h0000_1111);
    check("alu_wb_rd", wb_rd, 3);
    check("alu_wb_w_rd", wb_w_rd, 1);
    check("alu_wb_cr", {wb_w_cr, wb_cr}, 3'b110);
    check("alu_wb_pc", wb_pc, 32'h100);
    clr();
    step();
    check("bubble_wb_valid", wb_valid, 0);

    // lb sign-extended, ack on third request cycle
    clr(); ex_bus.bubble = 1'b0; ex_bus.mem_r = 1'b1; ex_bus.sz = 2'd0; ex_bus.mem_sx = 1'b1;
    ex_bus.alu_res = 32'h0000_1003; ex_bus.w_rd = 1'b1; ex_bus.rd = 5'd5;
    stalls = 0;
    #1 if (stall) stalls++;
    step();
    check("lb_dm_req", dm_req, 1);
    check("lb_dm_we", dm_we, 0);
    check("lb_dm_addr", dm_addr, 32'h0000_1000);
    check("lb_dm_be", dm_be, 4'b1000);
    if (stall) stalls++;
    step();
    if (stall) stalls++;
    step();
    dm_ack = 1'b1; dm_rdata = 32'h80FF_FF7F;
    #1 check("lb_stall_ack", stall, 0);
    check("lb_stall_cycles", stalls, 3);
    step();
    dm_ack = 1'b0; clr();
    check("lb_wb_valid", wb_valid, 1);
    check("lb_wb_data", wb_data, 32'hFFFF_FF80);
    check("lb_req_drop", dm_req, 0);

    // sh, ack in the first request cycle
    clr(); ex_bus.bubble = 1'b0; ex_bus.mem_w = 1'b1; ex_bus.sz = 2'd1;
    ex_bus.alu_res = 32'h0000_2002; ex_bus.op3 = 32'h1234_ABCD; ex_bus.w_rd = 1'b1;
    #1 check("sh_stall_issue", stall, 1);
    step();
    check("sh_dm_we", dm_we, 1);
    check("sh_dm_be", dm_be, 4'b1100);
    check("sh_dm_wdata", dm_wdata, 32'hABCD_ABCD);
    dm_ack = 1'b1;
    #1 check("sh_stall_ack", stall, 0);
    step();
    dm_ack = 1'b0; clr();
    check("sh_wb_valid", wb_valid, 1);
    check("sh_wb_w_rd", wb_w_rd, 0);

    // back-to-back: add, lw, link
    clr(); ex_bus.bubble = 1'b0; ex_bus.alu_res = 32'h55; ex_bus.w_rd = 1'b1;
    step();
    check("b2b_add", wb_data, 32'h55);
    clr(); ex_bus.bubble = 1'b0; ex_bus.mem_r = 1'b1; ex_bus.sz = 2'd2;
    ex_bus.alu_res = 32'h3000; ex_bus.w_rd = 1'b1;
    step();
    check("b2b_lw_req", dm_req, 1);
    check("b2b_lw_wbv", wb_valid, 0);
    dm_ack = 1'b1; dm_rdata = 32'hCAFE_F00D;
    step();
    dm_ack = 1'b0;
    check("b2b_lw_data", wb_data, 32'hCAFE_F00D);
    check("b2b_no_reissue", dm_req, 0);
    clr(); ex_bus.bubble = 1'b0; ex_bus.link = 1'b1; ex_bus.nextpc = 32'h44;
    ex_bus.alu_res = 32'h9999; ex_bus.w_rd = 1'b1;
    #1 check("b2b_link_stall", stall, 0);
    step();
    check("b2b_link_data", wb_data, 32'h44);
    check("b2b_link_noreq", dm_req, 0);
    clr();

    // udf + scall (with a load flag) -> cause 2, no bus op
    clr(); ex_bus.bubble = 1'b0; ex_bus.udf = 1'b1; ex_bus.scall = 1'b1;
    ex_bus.mem_r = 1'b1; ex_bus.w_rd = 1'b1; ex_bus.pc = 32'h300;
    #1 check("trap_stall", stall, 0);
    step();
    check("trap_exc_valid", exc_valid, 1);
    check("trap_cause", exc_cause, 2);
    check("trap_pc", exc_pc, 32'h300);
    check("trap_no_req", dm_req, 0);
    check("trap_w_rd", wb_w_rd, 0);
    clr();
    step();
    check("trap_pulse_end", exc_valid, 0);

    // eret alone -> cause 1
    clr(); ex_bus.bubble = 1'b0; ex_bus.eret = 1'b1; ex_bus.pc = 32'h310;
    step();
    check("eret_cause", exc_cause, 1);
    clr();

    // mtsr then mfsr
    clr(); ex_bus.bubble = 1'b0; ex_bus.mtsr = 1'b1; ex_bus.alu_res = 32'd7; ex_bus.op3 = 32'hDEAD;
    step();
    check("mtsr_we", sr_we, 1);
    check("mtsr_idx", sr_idx, 7);
    check("mtsr_wdata", sr_wdata, 32'hDEAD);
    clr();
    step();
    check("mtsr_once", sr_we, 0);
    clr(); ex_bus.bubble = 1'b0; ex_bus.mfsr = 1'b1; ex_bus.alu_res = 32'd9; ex_bus.w_rd = 1'b1;
    sr_rdata = 32'h77;
    #1 check("mfsr_idx", sr_idx, 9);
    step();
    check("mfsr_data", wb_data, 32'h77);
    clr(); ex_bus.bubble = 1'b0; ex_bus.mfcr = 1'b1; ex_bus.w_rd = 1'b1;
    step();
    check("mfcr_data", wb_data, 32'h0000_0C0C);
    clr();

    // IO read, raw data
    clr(); ex_bus.bubble = 1'b0; ex_bus.io_r = 1'b1; ex_bus.alu_res = 32'h00AB_CD12; ex_bus.w_rd = 1'b1;
    step();
    check("io_req", io_req, 1);
    check("io_addr", io_addr, 32'h0000_CD12);
    check("io_no_dm", dm_req, 0);
    io_ack = 1'b1; io_rdata = 32'h8765_4321;
    step();
    io_ack = 1'b0; clr();
    check("io_wb_data", wb_data, 32'h8765_4321);
    check("io_req_drop", io_req, 0);

    // misaligned lw at 0x1001
    clr(); ex_bus.bubble = 1'b0; ex_bus.mem_r = 1'b1; ex_bus.sz = 2'd2;
    ex_bus.alu_res = 32'h0000_1001; ex_bus.w_rd = 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
    step();
    check("mis_exc", exc_valid, 1);
    check("mis_cause", exc_cause, 3);
    check("mis_no_req", dm_req, 0);
    clr();
`else
    step();
    check("mis_addr", dm_addr, 32'h0000_1000);
    check("mis_be", dm_be, 4'hF);
    dm_ack = 1'b1;
    step();
    dm_ack = 1'b0; clr();
`endif
    step();

    // ack while idle is ignored
    dm_ack = 1'b1;
    step();
    dm_ack = 1'b0;
    check("idle_ack_wbv", wb_valid, 0);
    check("idle_ack_req", dm_req, 0);

    // reset mid DM_WAIT
    clr(); ex_bus.bubble = 1'b0; ex_bus.mem_r = 1'b1; ex_bus.sz = 2'd2; ex_bus.alu_res = 32'h4000;
    step();
    check("mid_req", dm_req, 1);
    rst = 1'b1;
    #1 check("mid_rst_req", dm_req, 0);
    check("mid_rst_stall", stall, 0);
    clr();
    step();
    rst = 1'b0;
    clr(); ex_bus.bubble = 1'b0; ex_bus.alu_res = 32'hA5A5; ex_bus.w_rd = 1'b1;
    #1 check("post_rst_stall", stall, 0);
    step();
    check("post_rst_wbv", wb_valid, 1);
    check("post_rst_data", wb_data, 32'hA5A5);
    clr();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
